// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU/MDU opcodes, forwarding selects, MDU state enum.
// Also holds a few small helpers used by the EX stage and the MDU engine.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;

  localparam logic [4:0] MDU_MULT  = 5'd16;
  localparam logic [4:0] MDU_MULTU = 5'd17;
  localparam logic [4:0] MDU_DIV   = 5'd18;
  localparam logic [4:0] MDU_DIVU  = 5'd19;
  localparam logic [4:0] MDU_MFHI  = 5'd20;
  localparam logic [4:0] MDU_MFLO  = 5'd21;

  localparam logic [1:0] FWD_IDEX = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the iterative engine (MFHI/MFLO only read HI/LO).
  function automatic logic is_mdu_iter_op(input logic [4:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative 32-step shift-add multiplier / restoring divider on operand magnitudes.
// Final result (sign-corrected) is presented combinationally while done is high.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   MDU_IDLE | waiting for start; operand latches hold last op
//   MDU_RUN  | one multiply/divide step per cycle, done on 32nd step
module mdu_iter
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  mdu_state_e        state_q, state_d;
  logic [5:0]        cnt_q;
  logic              is_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic [XLEN-1:0]   dividend_q, mag_b_q, acc_hi_q, acc_lo_q;
  logic [XLEN-1:0]   step_hi, step_lo, quo, rem;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic              signed_op, accept, last;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign accept    = start && (state_q == MDU_IDLE);
  assign last      = (cnt_q == 6'd31);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MDU_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MDU_IDLE: if (start) state_d = MDU_RUN;
      MDU_RUN: begin
        busy = 1'b1;
        if (last) begin
          done    = 1'b1;
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
      mag_b_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      is_div_q   <= (op == MDU_DIV) || (op == MDU_DIVU);
      neg_q_q    <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r_q    <= signed_op && a[XLEN-1];
      div_zero_q <= (b == '0);
      dividend_q <= a;
      mag_b_q    <= mag_of(b, signed_op);
      acc_hi_q   <= '0;
      acc_lo_q   <= mag_of(a, signed_op);
    end else if (busy) begin
      cnt_q    <= cnt_q + 6'd1;
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  // acc_lo holds the multiplier (shifted out LSB-first) or the dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q_q ? ('0 - {step_hi, step_lo}) : {step_hi, step_lo};
    quo    = neg_q_q ? ('0 - step_lo) : step_lo;
    rem    = neg_r_q ? ('0 - step_hi) : step_hi;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = dividend_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// EX pipeline stage: forwarding muxes, ALU, HI/LO, and the EX/MEM register.
// Multiply/divide runs in mdu_iter and stalls the front of the pipe while busy.
module ex_mdu_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] ext_in,
  input  logic [4:0]      shamt_in,
  input  logic [4:0]      aluctrl_in,
  input  logic            alusrc_in,
  input  logic            valid_in,
  input  logic            regw_in,
  input  logic            memr_in,
  input  logic            memw_in,
  input  logic            mem2r_in,
  input  logic [4:0]      reg_rd_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            flush,
  output logic            ex_stall,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic [4:0]      reg_rd_out,
  output logic            regw_out,
  output logic            memr_out,
  output logic            memw_out,
  output logic            mem2r_out,
  output logic            ovf_out
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, sum, diff;
  logic [XLEN-1:0] hi_q, lo_q, mdu_hi, mdu_lo;
  logic            ovf, is_mdu, mdu_start, mdu_busy, mdu_done, bubble;

  always_comb begin
    case (fwd_a_sel)
      FWD_MEM: src_a = mem_fwd_data;
      FWD_WB:  src_a = wb_fwd_data;
      default: src_a = rd1_in;
    endcase
    case (fwd_b_sel)
      FWD_MEM: fwd_b = mem_fwd_data;
      FWD_WB:  fwd_b = wb_fwd_data;
      default: fwd_b = rd2_in;
    endcase
    src_b = alusrc_in ? ext_in : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    sum     = src_a + src_b;
    diff    = src_a - src_b;
    case (aluctrl_in)
      ALU_ADD: begin
        alu_res = sum;
        ovf     = (src_a[XLEN-1] == src_b[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        ovf     = (src_a[XLEN-1] != src_b[XLEN-1]) && (diff[XLEN-1] != src_a[XLEN-1]);
      end
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_b << shamt_in;
      ALU_SRL:  alu_res = src_b >> shamt_in;
      ALU_SRA:  alu_res = $unsigned($signed(src_b) >>> shamt_in);
      ALU_LUI:  alu_res = {src_b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
      MDU_MFHI: alu_res = hi_q;
      MDU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  assign is_mdu    = is_mdu_iter_op(aluctrl_in);
  assign mdu_start = valid_in && is_mdu && !flush && !mdu_busy;
  assign ex_stall  = mdu_busy;
  assign bubble    = !valid_in || flush || ex_stall;

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (aluctrl_in),
    .a      (src_a),
    .b      (src_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .res_hi (mdu_hi),
    .res_lo (mdu_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mdu_done) begin
      hi_q <= mdu_hi;
      lo_q <= mdu_lo;
    end
  end

  // Data fields load every cycle; only the control bits define a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      pc_plus4_out   <= '0;
      reg_rd_out     <= '0;
      regw_out       <= 1'b0;
      memr_out       <= 1'b0;
      memw_out       <= 1'b0;
      mem2r_out      <= 1'b0;
      ovf_out        <= 1'b0;
    end else begin
      alu_result_out <= alu_res;
      store_data_out <= fwd_b;
      pc_plus4_out   <= pc_plus4_in;
      reg_rd_out     <= reg_rd_in;
      if (bubble) begin
        regw_out  <= 1'b0;
        memr_out  <= 1'b0;
        memw_out  <= 1'b0;
        mem2r_out <= 1'b0;
        ovf_out   <= 1'b0;
      end else begin
        regw_out  <= regw_in && !ovf && !is_mdu;
        memr_out  <= memr_in;
        memw_out  <= memw_in;
        mem2r_out <= mem2r_in;
        ovf_out   <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Scoreboard bench for ex_mdu_stage: driver queues expected EX/MEM results,
// a negedge monitor pops and compares whenever regw_out or ovf_out is set.
module tb_ex_mdu_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rd1_in, rd2_in, ext_in, pc_plus4_in, mem_fwd_data, wb_fwd_data;
  logic [4:0]  shamt_in, aluctrl_in, reg_rd_in;
  logic        alusrc_in, valid_in, regw_in, memr_in, memw_in, mem2r_in, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ex_stall;
  logic [31:0] alu_result_out, store_data_out, pc_plus4_out;
  logic [4:0]  reg_rd_out;
  logic        regw_out, memr_out, memw_out, mem2r_out, ovf_out;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] st;
    logic        regw;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ex_mdu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .ext_in(ext_in),
    .shamt_in(shamt_in), .aluctrl_in(aluctrl_in), .alusrc_in(alusrc_in),
    .valid_in(valid_in), .regw_in(regw_in), .memr_in(memr_in), .memw_in(memw_in),
    .mem2r_in(mem2r_in), .reg_rd_in(reg_rd_in), .pc_plus4_in(pc_plus4_in),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .flush(flush),
    .ex_stall(ex_stall), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .pc_plus4_out(pc_plus4_out), .reg_rd_out(reg_rd_out), .regw_out(regw_out),
    .memr_out(memr_out), .memw_out(memw_out), .mem2r_out(mem2r_out), .ovf_out(ovf_out)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst && (regw_out || ovf_out)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got res=%h regw=%b ovf=%b, required no output",
                 alu_result_out, regw_out, ovf_out);
      end else begin
        e = sb.pop_front();
        if (alu_result_out !== e.res || store_data_out !== e.st ||
            regw_out !== e.regw || ovf_out !== e.ovf) begin
          bad++;
          $display("FAIL %s: got res=%h st=%h regw=%b ovf=%b, required res=%h st=%h regw=%b ovf=%b",
                   e.name, alu_result_out, store_data_out, regw_out, ovf_out,
                   e.res, e.st, e.regw, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", n, got, req);
    end
  endtask

  task automatic push(input string n, input logic [31:0] r, input logic [31:0] st,
                      input logic rw, input logic ov);
    exp_t e;
    e.name = n; e.res = r; e.st = st; e.regw = rw; e.ovf = ov;
    sb.push_back(e);
  endtask

  // Called at a negedge; holds the instruction until a non-stalled posedge captures it.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, output int held);
    logic s;
    aluctrl_in = op; rd1_in = a; rd2_in = b;
    valid_in = 1'b1; regw_in = 1'b1; flush = fl;
    held = 0;
    s = 1'b1;
    while (s && held <= 100) begin
      s = ex_stall;
      @(posedge clk);
      if (s) held++;
      @(negedge clk);
    end
    if (held > 100) begin
      total++; bad++;
      $display("FAIL issue_timeout: got stall for %0d cycles, required release", held);
    end
    valid_in = 1'b0;
    flush = 1'b0;
  endtask

  task automatic alu(input string n, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic ov);
    int h;
    push(n, r, b, !ov, ov);
    issue(op, a, b, 1'b0, h);
  endtask

  initial begin
    int h, n;
    rd1_in = '0; rd2_in = '0; ext_in = '0; pc_plus4_in = 32'h100;
    mem_fwd_data = '0; wb_fwd_data = '0; shamt_in = '0; aluctrl_in = '0;
    reg_rd_in = 5'd3; alusrc_in = 1'b0; valid_in = 1'b0; regw_in = 1'b0;
    memr_in = 1'b0; memw_in = 1'b0; mem2r_in = 1'b0; flush = 1'b0;
    fwd_a_sel = FWD_IDEX; fwd_b_sel = FWD_IDEX;
    repeat (3) @(negedge clk);
    check("rst_alu_result", alu_result_out, 32'h0);
    check("rst_regw", 32'(regw_out), 32'h0);
    check("rst_stall", 32'(ex_stall), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    alu("add_ovf",    ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
    alu("sub_neg",    ALU_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 1'b0);
    alu("sub_ovf",    ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1);
    alu("and",        ALU_AND,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0);
    alu("or",         ALU_OR,   32'h0F0000F0, 32'h00F00F00, 32'h0FF00FF0, 1'b0);
    alu("xor",        ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0);
    alu("nor",        ALU_NOR,  32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0);
    alu("slt",        ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
    alu("sltu",       ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
    shamt_in = 5'd4;
    alu("sll",        ALU_SLL,  32'h0,        32'h3,        32'h30,       1'b0);
    alu("srl",        ALU_SRL,  32'h0,        32'h80000000, 32'h08000000, 1'b0);
    alu("sra",        ALU_SRA,  32'h0,        32'h80000000, 32'hF8000000, 1'b0);
    shamt_in = 5'd0;

    alusrc_in = 1'b1; ext_in = 32'h1234;
    push("lui_imm", 32'h12340000, 32'hAAAA, 1'b1, 1'b0);
    issue(ALU_LUI, 32'h0, 32'hAAAA, 1'b0, h);
    alusrc_in = 1'b0;

    fwd_a_sel = FWD_MEM; mem_fwd_data = 32'h10;
    alu("fwd_a_mem", ALU_ADD, 32'h0, 32'h2, 32'h12, 1'b0);
    fwd_a_sel = 2'd3;
    alu("fwd_a_rsvd", ALU_ADD, 32'h0, 32'h2, 32'h2, 1'b0);
    fwd_a_sel = FWD_IDEX;
    fwd_b_sel = FWD_WB; wb_fwd_data = 32'h55;
    push("fwd_b_wb", 32'h56, 32'h55, 1'b1, 1'b0);
    issue(ALU_ADD, 32'h1, 32'h9, 1'b0, h);
    fwd_b_sel = FWD_IDEX;

    issue(ALU_ADD, 32'h1, 32'h2, 1'b1, h);

    issue(MDU_MULT, 32'hFFFFFFFD, 32'h7, 1'b0, h);
    n = 0;
    while (ex_stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("mult_stall_cycles", 32'(n), 32'd32);
    alu("mult_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0);
    alu("mult_hi", MDU_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);

    issue(MDU_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, h);
    alu("multu_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0);
    alu("multu_hi", MDU_MFHI, 32'h0, 32'h0, 32'h1, 1'b0);

    issue(MDU_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, h);
    push("div_hi_held", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    issue(MDU_MFHI, 32'h0, 32'h0, 1'b0, h);
    check("mfhi_held_cycles", 32'(h), 32'd32);
    alu("div_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFD, 1'b0);

    issue(MDU_DIVU, 32'h9, 32'h0, 1'b0, h);
    alu("divu0_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
    alu("divu0_hi", MDU_MFHI, 32'h0, 32'h0, 32'h9, 1'b0);

    issue(MDU_DIV, 32'h7, 32'hFFFFFFFE, 1'b0, h);
    alu("div_pn_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFD, 1'b0);
    alu("div_pn_hi", MDU_MFHI, 32'h0, 32'h0, 32'h1, 1'b0);

    issue(MDU_MULT, 32'h5, 32'h6, 1'b0, h);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_run_stall", 32'(ex_stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    alu("rst_hi_clear", MDU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
    alu("rst_lo_clear", MDU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);

    issue(MDU_DIVU, 32'h9, 32'h0, 1'b0, h);
    alu("pre_flush_lo", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, h);
    check("flush_accept_no_stall", 32'(ex_stall), 32'h0);
    alu("flush_hi_kept", MDU_MFHI, 32'h0, 32'h0, 32'h9, 1'b0);
    alu("flush_lo_kept", MDU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mdu_stage.md
EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rd1_in, rd2_in, ext_in  in  32 each  ID/EX operands and extended immediate.
REQ-005 shamt_in  in  5  shift amount; aluctrl_in  in  5  operation code; alusrc_in  in  1  selects ext_in as operand B.
REQ-006 valid_in, regw_in, memr_in, memw_in, mem2r_in  in  1 each  ID/EX valid and control bits.
REQ-007 reg_rd_in  in  5  destination register; pc_plus4_in  in  32  return address.
REQ-008 fwd_a_sel, fwd_b_sel  in  2 each  operand source: 0 = ID/EX, 1 = mem_fwd_data, 2 = wb_fwd_data, 3 = reserved and treated as 0.
REQ-009 mem_fwd_data, wb_fwd_data  in  32 each  forwarded results.
REQ-010 flush  in  1  converts the current EX/MEM update into a bubble.
REQ-011 ex_stall  out  1  freezes PC, IF/ID and ID/EX while the MDU is busy.
REQ-012 alu_result_out, store_data_out, pc_plus4_out  out  32 each  registered EX/MEM data.
REQ-013 reg_rd_out  out  5; regw_out, memr_out, memw_out, mem2r_out, ovf_out  out  1 each  registered EX/MEM controls.

Function
REQ-014 The block SHALL compute operand A as the forwarding mux on rd1_in, and operand B as alusrc_in ? ext_in : the forwarding mux on rd2_in; store_data_out SHALL always take the forwarded rd2 value.
REQ-015 The ALU ops SHALL be ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL and SRA by shamt_in, and LUI (B<<16); each result SHALL register into EX/MEM one cycle after the inputs are presented (latency 1).
REQ-016 On signed overflow of ADD or SUB, the block SHALL register regw_out=0 and ovf_out=1 for that instruction.
REQ-017 The MDU ops SHALL be MULT, MULTU, DIV, DIVU, MFHI and MFLO; the block SHALL hold internal 32-bit registers HI and LO.
REQ-018 The MDU FSM SHALL have states IDLE and RUN.
REQ-019 IDLE->RUN: when valid_in is high, the op is MULT/MULTU/DIV/DIVU and flush is low, the block SHALL capture the operands and clear a 6-bit counter.
REQ-020 RUN SHALL perform one shift-add multiply or restoring-divide step per cycle, for exactly 32 cycles, on operand magnitudes.
REQ-021 On the 32nd RUN cycle, the block SHALL apply sign correction, write HI and LO, and return to IDLE.
REQ-022 Signed results: the product sign SHALL be A^B, the quotient sign A^B, and the remainder sign that of A.
REQ-023 Divide by zero SHALL give LO=32'hFFFFFFFF and HI=the dividend, with no exception.
REQ-024 ex_stall SHALL equal (state==RUN), combinationally; for an op accepted in cycle T, ex_stall SHALL be high T+1..T+32 and HI/LO SHALL be valid from T+33.
REQ-025 While ex_stall=1, the EX/MEM register SHALL be loaded with a bubble: all control outputs 0, data outputs don't-care.
REQ-026 The accepting cycle of a MULT/DIV SHALL register regw_out=0, because MDU ops do not write the GPR file.
REQ-027 MFHI and MFLO SHALL register HI or LO into alu_result_out with regw_out=regw_in; when they arrive during RUN they are held by ex_stall and complete in the first IDLE cycle.
REQ-028 flush=1 SHALL register a bubble and SHALL NOT abort an MDU op already in RUN.
REQ-029 When flush and an MDU accept occur in the same cycle, the op SHALL NOT start.
REQ-030 valid_in=0 SHALL register a bubble.

Reset
REQ-031 While rst is low, all registered outputs, HI, LO, the counter and the operand latches SHALL be 0, the FSM SHALL be IDLE, and ex_stall SHALL be 0; this holds including mid-RUN, and any partial MDU result is discarded.

Structure
REQ-032 The ALU and MDU opcode localparams, the forwarding-select encodings and the MDU state enum SHALL live in the shared cpu package.
REQ-033 The iterative multiply/divide engine SHALL be one sub-module, mdu_iter, with start/busy/done handshake; the ALU, forwarding muxes and EX/MEM register SHALL remain in ex_mdu_stage.

Verification
REQ-034 ADD A=32'h7FFFFFFF, B=1 -> next cycle ovf_out=1, regw_out=0; SUB 5-7 -> alu_result_out=32'hFFFFFFFE.
REQ-035 fwd_a_sel=1, mem_fwd_data=0x10, rd1_in=0, ADD with B=2 -> alu_result_out=0x12; fwd_a_sel=3 -> 2.
REQ-036 MULT -3 x 7 at T -> ex_stall high T+1..T+32, then MFLO -> 0xFFFFFFEB and MFHI -> 0xFFFFFFFF.
REQ-037 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
REQ-038 MFHI issued during RUN -> held, bubbles emitted, then the correct HI result registered one cycle after RUN ends.
REQ-039 rst low at RUN cycle 10 -> ex_stall=0 and HI=LO=0 immediately; flush coincident with DIVU accept -> no stall and HI/LO unchanged.
